// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage -- LC-3b pipeline MEM stage
//
// Takes the op latched in EX/MEM, runs the data-memory request/response
// handshake, formats load data and registers the result into MEM/WB.
// Supports LDR/STR (word), LDB/STB (byte) and LDI/STI (pointer fetch plus
// final access). The upstream pipeline is stalled while an access is
// outstanding.
//
// Parameters
//   TIMEOUT_CYC  cycles a request may wait for mem_resp before it is
//                aborted; 0 waits forever
//   REG_W        destination register index width
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   valid_in, mem_op_in         EX/MEM op (0 NONE,1 LDR,2 STR,3 LDB,4 STB,
//                               5 LDI,6 STI,7 NONE)
//   addr_in, sdata_in, alu_in   effective address, store data, ALU result
//   dest_in, ld_reg_in          destination register and its write enable
//   mem_read/mem_write          data-memory request strobes
//   mem_address/mem_wdata       request address and write data
//   mem_byte_enable             write byte lanes ([1] = high byte)
//   mem_resp, mem_rdata         memory completion and read data
//   stall_out                   hold EX/MEM and earlier stages
//   mdr_WB_in, dest_WB_in,
//   ld_reg_WB                   registered result into MEM/WB
//   mem_err                     one-cycle pulse on timeout / misalign trap
//
// Build option
//   MEM_ALIGN_TRAP_EN  when defined, a word op with addr_in[0]=1 issues no
//                      request and pulses mem_err instead; otherwise bit 0
//                      is silently cleared for word accesses.
// ---------------------------------------------------------------------------
module mem_access_stage #(
  parameter int TIMEOUT_CYC = 0,
  parameter int REG_W       = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [2:0]       mem_op_in,
  input  logic [15:0]      addr_in,
  input  logic [15:0]      sdata_in,
  input  logic [15:0]      alu_in,
  input  logic [REG_W-1:0] dest_in,
  input  logic             ld_reg_in,
  output logic             mem_read,
  output logic             mem_write,
  output logic [15:0]      mem_address,
  output logic [15:0]      mem_wdata,
  output logic [1:0]       mem_byte_enable,
  input  logic             mem_resp,
  input  logic [15:0]      mem_rdata,
  output logic             stall_out,
  output logic [15:0]      mdr_WB_in,
  output logic [REG_W-1:0] dest_WB_in,
  output logic             ld_reg_WB,
  output logic             mem_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_IND_RD = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  logic [1:0]       r_state;
  logic             r_is_store, r_is_byte, r_byte_hi, r_ld_reg, r_ptr_ready;
  logic [REG_W-1:0] r_dest;
  logic [15:0]      r_sdata;
  logic [CNT_W-1:0] r_to_cnt;
  logic             r_mem_read, r_mem_write, r_ld_reg_wb, r_mem_err;
  logic [15:0]      r_mem_address, r_mem_wdata, r_mdr;
  logic [1:0]       r_mem_be;
  logic [REG_W-1:0] r_dest_wb;

  logic        w_op_mem, w_is_ind, w_is_byte, w_is_store;
  logic        w_is_mem, w_misalign, w_timeout;
  logic [15:0] w_word_addr, w_load_data;

  always_comb begin
    w_op_mem   = 1'b1;
    w_is_ind   = 1'b0;
    w_is_byte  = 1'b0;
    w_is_store = 1'b0;
    case (mem_op_in)
      3'd1: ;
      3'd2: w_is_store = 1'b1;
      3'd3: w_is_byte = 1'b1;
      3'd4: begin w_is_byte = 1'b1; w_is_store = 1'b1; end
      3'd5: w_is_ind = 1'b1;
      3'd6: begin w_is_ind = 1'b1; w_is_store = 1'b1; end
      default: w_op_mem = 1'b0;  // NONE and reserved 7
    endcase
  end

  assign w_is_mem    = valid_in & w_op_mem;
  assign w_word_addr = {addr_in[15:1], 1'b0};

`ifdef MEM_ALIGN_TRAP_EN
  assign w_misalign = w_is_mem & ~w_is_byte & addr_in[0];
`else
  assign w_misalign = 1'b0;
`endif

  // Only meaningful while a request is on the bus; never fires when TIMEOUT_CYC = 0.
  assign w_timeout = (TIMEOUT_CYC > 0) && (r_to_cnt == TO_LAST);

  assign w_load_data = !r_is_byte ? mem_rdata :
                       (r_byte_hi ? {8'h00, mem_rdata[15:8]} : {8'h00, mem_rdata[7:0]});

  // Gated by rst_n so the stall also reads 0 while reset is held.
  assign stall_out = rst_n & (((r_state == S_IDLE) & w_is_mem) |
                              (r_state == S_IND_RD) | (r_state == S_ACCESS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_is_store    <= 1'b0;
      r_is_byte     <= 1'b0;
      r_byte_hi     <= 1'b0;
      r_ld_reg      <= 1'b0;
      r_ptr_ready   <= 1'b0;
      r_dest        <= '0;
      r_sdata       <= 16'h0000;
      r_to_cnt      <= '0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= 16'h0000;
      r_mem_wdata   <= 16'h0000;
      r_mem_be      <= 2'b00;
      r_mdr         <= 16'h0000;
      r_dest_wb     <= '0;
      r_ld_reg_wb   <= 1'b0;
      r_mem_err     <= 1'b0;
    end else begin
      r_mem_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_to_cnt    <= '0;
          r_ptr_ready <= 1'b0;
          if (w_is_mem) begin
            r_ld_reg_wb <= 1'b0;
            r_is_store  <= w_is_store;
            r_is_byte   <= w_is_byte;
            r_byte_hi   <= addr_in[0];
            r_dest      <= dest_in;
            r_ld_reg    <= ld_reg_in;
            r_sdata     <= sdata_in;
            if (w_misalign) begin
              r_mem_err <= 1'b1;
              r_state   <= S_DONE;
            end else if (w_is_ind) begin
              r_mem_read    <= 1'b1;
              r_mem_address <= w_word_addr;
              r_state       <= S_IND_RD;
            end else begin
              r_mem_read    <= ~w_is_store;
              r_mem_write   <= w_is_store;
              r_mem_address <= w_is_byte ? addr_in : w_word_addr;
              r_mem_wdata   <= w_is_byte ? {2{sdata_in[7:0]}} : sdata_in;
              r_mem_be      <= !w_is_store ? 2'b00 :
                               (!w_is_byte ? 2'b11 : (addr_in[0] ? 2'b10 : 2'b01));
              r_state       <= S_ACCESS;
            end
          end else if (valid_in) begin
            r_mdr       <= alu_in;
            r_dest_wb   <= dest_in;
            r_ld_reg_wb <= ld_reg_in;
          end else begin
            r_ld_reg_wb <= 1'b0;
          end
        end

        S_IND_RD: begin
          if (r_ptr_ready) begin
            // One idle bus cycle has passed since the pointer arrived.
            r_ptr_ready <= 1'b0;
            r_to_cnt    <= '0;
            r_mem_read  <= ~r_is_store;
            r_mem_write <= r_is_store;
            r_mem_wdata <= r_sdata;
            r_mem_be    <= r_is_store ? 2'b11 : 2'b00;
            r_state     <= S_ACCESS;
          end else if (mem_resp) begin
            r_mem_read    <= 1'b0;
            r_mem_address <= {mem_rdata[15:1], 1'b0};
            r_ptr_ready   <= 1'b1;
            r_to_cnt      <= '0;
          end else if (w_timeout) begin
            r_mem_read  <= 1'b0;
            r_mem_err   <= 1'b1;
            r_ld_reg_wb <= 1'b0;
            r_state     <= S_DONE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end

        S_ACCESS: begin
          if (mem_resp) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_be    <= 2'b00;
            r_dest_wb   <= r_dest;
            r_ld_reg_wb <= ~r_is_store & r_ld_reg;
            if (!r_is_store) r_mdr <= w_load_data;
            r_state     <= S_DONE;
          end else if (w_timeout) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_be    <= 2'b00;
            r_mem_err   <= 1'b1;
            r_ld_reg_wb <= 1'b0;
            r_state     <= S_DONE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end

        default: begin  // S_DONE: result already presented, drop the WB enable
          r_ld_reg_wb <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_read        = r_mem_read;
  assign mem_write       = r_mem_write;
  assign mem_address     = r_mem_address;
  assign mem_wdata       = r_mem_wdata;
  assign mem_byte_enable = r_mem_be;
  assign mdr_WB_in       = r_mdr;
  assign dest_WB_in      = r_dest_wb;
  assign ld_reg_WB       = r_ld_reg_wb;
  assign mem_err         = r_mem_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage (TIMEOUT_CYC = 8, default build).
module tb_mem_access_stage;
  localparam int REG_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             valid_in = 1'b0;
  logic [2:0]       mem_op_in = 3'd0;
  logic [15:0]      addr_in = 16'h0, sdata_in = 16'h0, alu_in = 16'h0;
  logic [REG_W-1:0] dest_in = '0;
  logic             ld_reg_in = 1'b0;
  logic             mem_read, mem_write;
  logic [15:0]      mem_address, mem_wdata;
  logic [1:0]       mem_byte_enable;
  logic             mem_resp = 1'b0;
  logic [15:0]      mem_rdata = 16'h0;
  logic             stall_out;
  logic [15:0]      mdr_WB_in;
  logic [REG_W-1:0] dest_WB_in;
  logic             ld_reg_WB, mem_err;

  int total = 0;
  int bad   = 0;

  mem_access_stage #(.TIMEOUT_CYC(8), .REG_W(REG_W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .mem_op_in(mem_op_in),
    .addr_in(addr_in), .sdata_in(sdata_in), .alu_in(alu_in), .dest_in(dest_in),
    .ld_reg_in(ld_reg_in), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_byte_enable(mem_byte_enable), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .stall_out(stall_out), .mdr_WB_in(mdr_WB_in), .dest_WB_in(dest_WB_in),
    .ld_reg_WB(ld_reg_WB), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_in  = 1'b0;
    mem_op_in = 3'd0;
    mem_resp  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) cyc();
    total++;
    if ({mem_read, mem_write, stall_out, ld_reg_WB, mem_err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got rd/wr/stall/ld/err=%b required 00000",
               {mem_read, mem_write, stall_out, ld_reg_WB, mem_err});
    end
    total++;
    if (mem_address !== 16'h0 || mem_wdata !== 16'h0 || mdr_WB_in !== 16'h0) begin
      bad++;
      $display("FAIL reset_data: got addr=%h wdata=%h mdr=%h required 0000",
               mem_address, mem_wdata, mdr_WB_in);
    end
    total++;
    if (dest_WB_in !== '0 || mem_byte_enable !== 2'b00) begin
      bad++;
      $display("FAIL reset_misc: got dest=%0d be=%b required 0/00", dest_WB_in, mem_byte_enable);
    end
    $display("txn RESET done");
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_passthru();
    logic [2:0]       ops  [3] = '{3'd0, 3'd7, 3'd0};
    logic [15:0]      alus [3] = '{16'h1234, 16'hABCD, 16'h0F0F};
    logic [REG_W-1:0] dsts [3] = '{3'd5, 3'd6, 3'd1};
    logic             lds  [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1; mem_op_in = ops[i]; alu_in = alus[i];
      dest_in = dsts[i]; ld_reg_in = lds[i];
      #1;
      total++;
      if (stall_out !== 1'b0) begin
        bad++; $display("FAIL pass_stall[%0d]: got %b required 0", i, stall_out);
      end
      cyc();
      total++;
      if (mdr_WB_in !== alus[i] || dest_WB_in !== dsts[i] || ld_reg_WB !== lds[i]) begin
        bad++;
        $display("FAIL pass_wb[%0d]: got mdr=%h dest=%0d ld=%b required mdr=%h dest=%0d ld=%b",
                 i, mdr_WB_in, dest_WB_in, ld_reg_WB, alus[i], dsts[i], lds[i]);
      end
      $display("txn PASS op=%0d alu=%h -> mdr=%h", ops[i], alus[i], mdr_WB_in);
    end
    idle_inputs();
    cyc();
    total++;
    if (ld_reg_WB !== 1'b0) begin
      bad++; $display("FAIL bubble_ld: got %b required 0", ld_reg_WB);
    end
  endtask

  task automatic test_ldr();
    int n_stall = 0;
    valid_in = 1'b1; mem_op_in = 3'd1; addr_in = 16'h3001;
    dest_in = 3'd2; ld_reg_in = 1'b1;
    #1;
    total++;
    if (stall_out !== 1'b1) begin
      bad++; $display("FAIL ldr_stall_idle: got %b required 1", stall_out);
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (stall_out) n_stall++;
      total++;
      if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 16'h3000) begin
        bad++;
        $display("FAIL ldr_req[%0d]: got rd=%b wr=%b addr=%h required rd=1 wr=0 addr=3000",
                 k, mem_read, mem_write, mem_address);
      end
      if (k == 3) begin mem_resp = 1'b1; mem_rdata = 16'hBEEF; end
    end
    cyc();
    mem_resp = 1'b0; valid_in = 1'b0;
    total++;
    if (n_stall !== 4) begin
      bad++; $display("FAIL ldr_stall_cnt: got %0d required 4", n_stall);
    end
    total++;
    if (mdr_WB_in !== 16'hBEEF || ld_reg_WB !== 1'b1 || dest_WB_in !== 3'd2) begin
      bad++;
      $display("FAIL ldr_wb: got mdr=%h ld=%b dest=%0d required BEEF/1/2", mdr_WB_in, ld_reg_WB, dest_WB_in);
    end
    total++;
    if (mem_read !== 1'b0 || stall_out !== 1'b0) begin
      bad++; $display("FAIL ldr_done: got rd=%b stall=%b required 0/0", mem_read, stall_out);
    end
    $display("txn LDR addr=3001 -> mdr=%h", mdr_WB_in);
    cyc();
    total++;
    if (ld_reg_WB !== 1'b0) begin
      bad++; $display("FAIL ldr_ld_drop: got %b required 0", ld_reg_WB);
    end
  endtask

  task automatic test_ldb();
    logic [15:0] addrs [2] = '{16'h2005, 16'h2004};
    logic [15:0] exps  [2] = '{16'h0012, 16'h00AB};
    for (int i = 0; i < 2; i++) begin
      valid_in = 1'b1; mem_op_in = 3'd3; addr_in = addrs[i];
      dest_in = 3'd4; ld_reg_in = 1'b1;
      cyc();
      total++;
      if (mem_read !== 1'b1 || mem_address !== addrs[i]) begin
        bad++;
        $display("FAIL ldb_req[%0d]: got rd=%b addr=%h required rd=1 addr=%h", i, mem_read, mem_address, addrs[i]);
      end
      mem_resp = 1'b1; mem_rdata = 16'h12AB;
      cyc();
      idle_inputs();
      total++;
      if (mdr_WB_in !== exps[i] || ld_reg_WB !== 1'b1) begin
        bad++;
        $display("FAIL ldb_data[%0d]: got mdr=%h ld=%b required mdr=%h ld=1", i, mdr_WB_in, ld_reg_WB, exps[i]);
      end
      $display("txn LDB addr=%h -> mdr=%h", addrs[i], mdr_WB_in);
      cyc();
    end
  endtask

  task automatic test_store();
    logic [2:0]  ops   [2] = '{3'd4, 3'd2};
    logic [15:0] addrs [2] = '{16'h2005, 16'h2001};
    logic [15:0] sds   [2] = '{16'h00C3, 16'h5A5A};
    logic [15:0] eaddr [2] = '{16'h2005, 16'h2000};
    logic [15:0] ewd   [2] = '{16'hC3C3, 16'h5A5A};
    logic [1:0]  ebe   [2] = '{2'b10, 2'b11};
    for (int i = 0; i < 2; i++) begin
      valid_in = 1'b1; mem_op_in = ops[i]; addr_in = addrs[i]; sdata_in = sds[i];
      dest_in = 3'd3; ld_reg_in = 1'b1;
      cyc();
      total++;
      if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== eaddr[i] ||
          mem_wdata !== ewd[i] || mem_byte_enable !== ebe[i]) begin
        bad++;
        $display("FAIL store_req[%0d]: got wr=%b rd=%b addr=%h wd=%h be=%b required wr=1 rd=0 addr=%h wd=%h be=%b",
                 i, mem_write, mem_read, mem_address, mem_wdata, mem_byte_enable, eaddr[i], ewd[i], ebe[i]);
      end
      mem_resp = 1'b1;
      cyc();
      idle_inputs();
      total++;
      if (ld_reg_WB !== 1'b0 || mem_write !== 1'b0 || mem_err !== 1'b0) begin
        bad++;
        $display("FAIL store_done[%0d]: got ld=%b wr=%b err=%b required 0/0/0", i, ld_reg_WB, mem_write, mem_err);
      end
      $display("txn STORE op=%0d addr=%h wdata=%h", ops[i], addrs[i], ewd[i]);
      cyc();
    end
  endtask

  task automatic test_ldi();
    valid_in = 1'b1; mem_op_in = 3'd5; addr_in = 16'h4000;
    dest_in = 3'd1; ld_reg_in = 1'b1;
    cyc();
    total++;
    if (mem_read !== 1'b1 || mem_address !== 16'h4000) begin
      bad++; $display("FAIL ldi_ptr_req: got rd=%b addr=%h required rd=1 addr=4000", mem_read, mem_address);
    end
    mem_resp = 1'b1; mem_rdata = 16'h5003;
    cyc();
    // gap cycle: no request, stray resp must be ignored
    mem_resp = 1'b1; mem_rdata = 16'hFFFF;
    total++;
    if (mem_read !== 1'b0 || stall_out !== 1'b1) begin
      bad++; $display("FAIL ldi_gap: got rd=%b stall=%b required rd=0 stall=1", mem_read, stall_out);
    end
    cyc();
    mem_resp = 1'b0;
    total++;
    if (mem_read !== 1'b1 || mem_address !== 16'h5002 || stall_out !== 1'b1) begin
      bad++;
      $display("FAIL ldi_final_req: got rd=%b addr=%h stall=%b required rd=1 addr=5002 stall=1",
               mem_read, mem_address, stall_out);
    end
    cyc();
    mem_resp = 1'b1; mem_rdata = 16'h7777;
    cyc();
    idle_inputs();
    total++;
    if (mdr_WB_in !== 16'h7777 || ld_reg_WB !== 1'b1 || mem_read !== 1'b0) begin
      bad++;
      $display("FAIL ldi_wb: got mdr=%h ld=%b rd=%b required 7777/1/0", mdr_WB_in, ld_reg_WB, mem_read);
    end
    $display("txn LDI addr=4000 -> mdr=%h", mdr_WB_in);
    cyc();
  endtask

  task automatic test_timeout();
    int n_req = 0;
    valid_in = 1'b1; mem_op_in = 3'd1; addr_in = 16'h1000;
    dest_in = 3'd6; ld_reg_in = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (mem_read) n_req++;
      else break;
    end
    total++;
    if (n_req !== 8) begin
      bad++; $display("FAIL timeout_len: got %0d request cycles required 8", n_req);
    end
    total++;
    if (mem_err !== 1'b1 || ld_reg_WB !== 1'b0 || stall_out !== 1'b0) begin
      bad++;
      $display("FAIL timeout_abort: got err=%b ld=%b stall=%b required 1/0/0", mem_err, ld_reg_WB, stall_out);
    end
    idle_inputs();
    $display("txn TIMEOUT LDR addr=1000 request cycles=%0d", n_req);
    cyc();
    total++;
    if (mem_err !== 1'b0) begin
      bad++; $display("FAIL timeout_pulse: got err=%b required 0", mem_err);
    end
  endtask

  task automatic test_reset_mid();
    valid_in = 1'b1; mem_op_in = 3'd1; addr_in = 16'h6000;
    dest_in = 3'd7; ld_reg_in = 1'b1;
    cyc();
    total++;
    if (mem_read !== 1'b1) begin
      bad++; $display("FAIL rstmid_req: got rd=%b required 1", mem_read);
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (mem_read !== 1'b0 || stall_out !== 1'b0 || mem_address !== 16'h0) begin
      bad++;
      $display("FAIL rstmid_drop: got rd=%b stall=%b addr=%h required 0/0/0000", mem_read, stall_out, mem_address);
    end
    idle_inputs();
    cyc();
    rst_n = 1'b1;
    valid_in = 1'b1; mem_op_in = 3'd0; alu_in = 16'h5555; dest_in = 3'd7; ld_reg_in = 1'b1;
    cyc();
    idle_inputs();
    total++;
    if (mdr_WB_in !== 16'h5555 || ld_reg_WB !== 1'b1 || mem_read !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_add: got mdr=%h ld=%b rd=%b required 5555/1/0", mdr_WB_in, ld_reg_WB, mem_read);
    end
    $display("txn RESET_MID then ADD -> mdr=%h", mdr_WB_in);
    cyc();
  endtask

  initial begin
    test_reset();
    test_passthru();
    test_ldr();
    test_ldb();
    test_store();
    test_ldi();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
